// File: rtl/pipe_pkg.sv
// Shared types for the RV32 pipeline registers: writeback select encoding,
// EX/MEM control bundle and the elastic-buffer occupancy states.
package pipe_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wbsel_e;

    // Control bits sit in front of the data words so a bubble can be zeroed as one slice.
    typedef struct packed {
        logic   regWEn;
        wbsel_e wbSel;
        logic   stEn;
        logic   sb;
        logic   sh;
    } ex_mem_ctrl_t;

    typedef struct packed {
        ex_mem_ctrl_t    ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] dataB;
        logic [XLEN-1:0] inst;
    } ex_mem_payload_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry (main + skid) valid/ready buffer with synchronous flush.
// The output always comes from the main register; in_ready depends only on state.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DataW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DataW-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DataW-1:0] out_data_o
);

    buf_state_e       stateQ, stateD;
    logic [DataW-1:0] mainQ, mainD;
    logic [DataW-1:0] skidQ, skidD;
    logic             mainLoad, skidLoad;
    logic             accept, drain;

    assign in_ready_o  = (stateQ != BUF_TWO);
    assign out_valid_o = (stateQ != BUF_EMPTY);
    assign out_data_o  = mainQ;

    assign accept = in_valid_i & in_ready_o;
    assign drain  = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ <= BUF_EMPTY;
        end else begin
            stateQ <= stateD;
        end
    end

    // Payload registers only load on accept/drain/flush so a held entry never toggles.
    always_comb begin
        stateD   = stateQ;
        mainLoad = 1'b0;
        skidLoad = 1'b0;
        mainD    = in_data_i;
        skidD    = in_data_i;
        if (flush_i) begin
            stateD   = BUF_EMPTY;
            mainLoad = 1'b1;
            skidLoad = 1'b1;
            mainD    = '0;
            skidD    = '0;
        end else begin
            case (stateQ)
                BUF_EMPTY: begin
                    if (accept) begin
                        stateD   = BUF_ONE;
                        mainLoad = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (drain && accept) begin
                        mainLoad = 1'b1;
                    end else if (drain) begin
                        stateD = BUF_EMPTY;
                    end else if (accept) begin
                        stateD   = BUF_TWO;
                        skidLoad = 1'b1;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        stateD   = BUF_ONE;
                        mainLoad = 1'b1;
                        mainD    = skidQ;
                    end
                end
                default: begin
                    stateD = BUF_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mainQ <= '0;
            skidQ <= '0;
        end else begin
            if (mainLoad) begin
                mainQ <= mainD;
            end
            if (skidLoad) begin
                skidQ <= skidD;
            end
        end
    end

endmodule

// File: rtl/reg_ex_mem_elastic.sv
// EX/MEM pipeline register built on a 2-entry elastic buffer, with bubble
// qualification of control outputs and a saturating MEM-stall counter.
module reg_ex_mem_elastic
    import pipe_pkg::*;
#(
    parameter int Width    = 32,
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                RegWEn_EX_i,
    input  logic [1:0]          WBSel_EX_i,
    input  logic                st_en_EX_i,
    input  logic                SB_EX_i,
    input  logic                SH_EX_i,
    input  logic [Width-1:0]    pc_EX_i,
    input  logic [Width-1:0]    alu_EX_i,
    input  logic [Width-1:0]    DataB_EX_i,
    input  logic [Width-1:0]    inst_EX_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                RegWEn_MEM_o,
    output logic                st_en_MEM_o,
    output logic                SB_MEM_o,
    output logic                SH_MEM_o,
    output logic [1:0]          WBSel_MEM_o,
    output logic [Width-1:0]    pc_MEM_o,
    output logic [Width-1:0]    alu_MEM_o,
    output logic [Width-1:0]    DataB_MEM_o,
    output logic [Width-1:0]    inst_MEM_o,
    output logic [CntWidth-1:0] stall_cnt_o
);

    localparam int CtrlW    = $bits(ex_mem_ctrl_t);
    localparam int PayloadW = CtrlW + 4 * Width;

    ex_mem_ctrl_t        inCtrl, outCtrl;
    logic [PayloadW-1:0] inPayload, outPayload;
    logic                outValid;
    logic [CntWidth-1:0] stallCntQ, stallCntD;

    always_comb begin
        inCtrl        = '0;
        inCtrl.regWEn = RegWEn_EX_i;
        inCtrl.wbSel  = wbsel_e'(WBSel_EX_i);
        inCtrl.stEn   = st_en_EX_i;
        inCtrl.sb     = SB_EX_i;
        inCtrl.sh     = SH_EX_i;
    end

    assign inPayload = {inCtrl, pc_EX_i, alu_EX_i, DataB_EX_i, inst_EX_i};

    pipe_skid_buf #(
        .DataW(PayloadW)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (inPayload),
        .out_valid_o (outValid),
        .out_ready_i (out_ready_i),
        .out_data_o  (outPayload)
    );

    assign {outCtrl, pc_MEM_o, alu_MEM_o, DataB_MEM_o, inst_MEM_o} = outPayload;

    // A bubble must never write the register file or memory.
    assign out_valid_o  = outValid;
    assign RegWEn_MEM_o = outValid & outCtrl.regWEn;
    assign st_en_MEM_o  = outValid & outCtrl.stEn;
    assign SB_MEM_o     = outValid & outCtrl.sb;
    assign SH_MEM_o     = outValid & outCtrl.sh;
    assign WBSel_MEM_o  = outValid ? outCtrl.wbSel : WB_ALU;

    // Flush deliberately leaves the counter alone; it tracks MEM wait states only.
    always_comb begin
        stallCntD = stallCntQ;
        if (outValid && !out_ready_i && (stallCntQ != {CntWidth{1'b1}})) begin
            stallCntD = stallCntQ + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stallCntQ <= '0;
        end else begin
            stallCntQ <= stallCntD;
        end
    end

    assign stall_cnt_o = stallCntQ;

endmodule

// File: tb/tb_reg_ex_mem_elastic.sv
// Directed bench for reg_ex_mem_elastic: reset, streaming, backpressure,
// flush, bubble qualification and stall-counter saturation (CntWidth=4).
module tb_reg_ex_mem_elastic;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rstN;
    logic          flush;
    logic          inValid;
    logic          inReady;
    logic          regWEnEx;
    logic [1:0]    wbSelEx;
    logic          stEnEx, sbEx, shEx;
    logic [W-1:0]  pcEx, aluEx, dataBEx, instEx;
    logic          outValid;
    logic          outReady;
    logic          regWEnMem, stEnMem, sbMem, shMem;
    logic [1:0]    wbSelMem;
    logic [W-1:0]  pcMem, aluMem, dataBMem, instMem;
    logic [CW-1:0] stallCnt;
    logic          forceCtl;

    int checkCount;
    int errCount;

    reg_ex_mem_elastic #(
        .Width    (W),
        .CntWidth (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .flush_i      (flush),
        .in_valid_i   (inValid),
        .in_ready_o   (inReady),
        .RegWEn_EX_i  (regWEnEx),
        .WBSel_EX_i   (wbSelEx),
        .st_en_EX_i   (stEnEx),
        .SB_EX_i      (sbEx),
        .SH_EX_i      (shEx),
        .pc_EX_i      (pcEx),
        .alu_EX_i     (aluEx),
        .DataB_EX_i   (dataBEx),
        .inst_EX_i    (instEx),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .RegWEn_MEM_o (regWEnMem),
        .st_en_MEM_o  (stEnMem),
        .SB_MEM_o     (sbMem),
        .SH_MEM_o     (shMem),
        .WBSel_MEM_o  (wbSelMem),
        .pc_MEM_o     (pcMem),
        .alu_MEM_o    (aluMem),
        .DataB_MEM_o  (dataBMem),
        .inst_MEM_o   (instMem),
        .stall_cnt_o  (stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every other payload field is derived from pc so one number identifies an entry.
    task automatic applyStimulus(input logic v, input logic [W-1:0] pc, input logic rdy, input logic fl);
        inValid  = v;
        pcEx     = pc;
        aluEx    = pc + 32'h1000;
        dataBEx  = ~pc;
        instEx   = pc ^ 32'hA5A5_0000;
        regWEnEx = 1'b1 | forceCtl;
        wbSelEx  = pc[3:2];
        stEnEx   = pc[2] | forceCtl;
        sbEx     = pc[3];
        shEx     = pc[4];
        outReady = rdy;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        forceCtl   = 1'b0;
        rstN       = 1'b0;
        flush      = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b1;
        regWEnEx   = 1'b0;
        wbSelEx    = 2'd0;
        stEnEx     = 1'b0;
        sbEx       = 1'b0;
        shEx       = 1'b0;
        pcEx       = '0;
        aluEx      = '0;
        dataBEx    = '0;
        instEx     = '0;

        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_in_ready", 64'(inReady), 64'd1);
        checkOutput("rst_pc", 64'(pcMem), 64'd0);
        checkOutput("rst_stall", 64'(stallCnt), 64'd0);
        rstN = 1'b1;

        // Streaming with MEM always ready
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        checkOutput("stream0_valid", 64'(outValid), 64'd1);
        checkOutput("stream0_pc", 64'(pcMem), 64'h0);
        checkOutput("stream0_alu", 64'(aluMem), 64'h1000);
        checkOutput("stream0_ready", 64'(inReady), 64'd1);
        applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
        checkOutput("stream1_pc", 64'(pcMem), 64'h4);
        checkOutput("stream1_st_en", 64'(stEnMem), 64'd1);
        checkOutput("stream1_ready", 64'(inReady), 64'd1);
        applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
        checkOutput("stream2_pc", 64'(pcMem), 64'h8);
        checkOutput("stream2_wbsel", 64'(wbSelMem), 64'd2);
        checkOutput("stream2_sb", 64'(sbMem), 64'd1);
        checkOutput("stream2_datab", 64'(dataBMem), 64'hFFFF_FFF7);
        checkOutput("stream2_inst", 64'(instMem), 64'hA5A5_0008);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("stream_end_valid", 64'(outValid), 64'd0);
        checkOutput("stream_end_regwen", 64'(regWEnMem), 64'd0);
        checkOutput("stream_stall", 64'(stallCnt), 64'd0);

        // Backpressure: A into main, B into skid, C held off
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
        checkOutput("bp_a_pc", 64'(pcMem), 64'h100);
        checkOutput("bp_a_ready", 64'(inReady), 64'd1);
        checkOutput("bp_a_stall", 64'(stallCnt), 64'd0);
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b0);
        checkOutput("bp_b_pc", 64'(pcMem), 64'h100);
        checkOutput("bp_b_ready", 64'(inReady), 64'd0);
        checkOutput("bp_b_stall", 64'(stallCnt), 64'd1);
        applyStimulus(1'b1, 32'h108, 1'b0, 1'b0);
        checkOutput("bp_hold_pc", 64'(pcMem), 64'h100);
        checkOutput("bp_hold_stall", 64'(stallCnt), 64'd2);
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0);
        checkOutput("bp_drain_b_pc", 64'(pcMem), 64'h104);
        checkOutput("bp_drain_b_ready", 64'(inReady), 64'd1);
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0);
        checkOutput("bp_drain_c_pc", 64'(pcMem), 64'h108);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_empty_valid", 64'(outValid), 64'd0);
        checkOutput("bp_final_stall", 64'(stallCnt), 64'd2);

        // Flush with a simultaneous accept
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h204, 1'b0, 1'b0);
        checkOutput("fl_full_ready", 64'(inReady), 64'd0);
        checkOutput("fl_full_stall", 64'(stallCnt), 64'd3);
        applyStimulus(1'b1, 32'h208, 1'b0, 1'b1);
        checkOutput("fl_valid", 64'(outValid), 64'd0);
        checkOutput("fl_ready", 64'(inReady), 64'd1);
        checkOutput("fl_pc", 64'(pcMem), 64'd0);
        checkOutput("fl_stall_kept", 64'(stallCnt), 64'd4);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("fl_no_deliver", 64'(outValid), 64'd0);

        // Bubble qualification: store control present but not valid
        forceCtl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h1C, 1'b1, 1'b0);
            checkOutput("bubble_st_en", 64'(stEnMem), 64'd0);
            checkOutput("bubble_regwen", 64'(regWEnMem), 64'd0);
        end
        forceCtl = 1'b0;

        // Asynchronous reset with both entries full
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h304, 1'b0, 1'b0);
        checkOutput("ar_full_ready", 64'(inReady), 64'd0);
        checkOutput("ar_full_stall", 64'(stallCnt), 64'd5);
        inValid = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("ar_valid", 64'(outValid), 64'd0);
        checkOutput("ar_ready", 64'(inReady), 64'd1);
        checkOutput("ar_pc", 64'(pcMem), 64'd0);
        checkOutput("ar_alu", 64'(aluMem), 64'd0);
        checkOutput("ar_stall", 64'(stallCnt), 64'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Saturation of the 4-bit stall counter
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0);
        checkOutput("sat_start", 64'(stallCnt), 64'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        end
        checkOutput("sat_five", 64'(stallCnt), 64'd5);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        end
        checkOutput("sat_twenty", 64'(stallCnt), 64'hF);
        checkOutput("sat_pc_held", 64'(pcMem), 64'h400);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        end
        checkOutput("sat_stays", 64'(stallCnt), 64'hF);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
